// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their *W forms.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero skips iteration, word ops run 32 iterations.
module div_radix2 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [2:0]      div_op,
  input  logic            req_valid,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_result
);

  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [6:0]      cnt_q;
  logic [6:0]      last_cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_mag_q;
  logic [XLEN-1:0] dvnd_prep_q;
  logic            unsigned_q;
  logic            want_rem_q;
  logic            word_q;
  logic            dvnd_neg_q;
  logic            dvsr_neg_q;
  logic            dvsr_zero_q;

  logic            accept;
  logic [XLEN-1:0] op1_ext;
  logic [XLEN-1:0] op2_ext;
  logic            op1_neg;
  logic            op2_neg;
  logic [XLEN-1:0] op1_mag;
  logic [XLEN-1:0] op2_mag;
  logic            op2_zero;
  logic [XLEN-1:0] quo_init;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            rem_ge;
  logic [XLEN-1:0] rem_nxt;

  logic [XLEN-1:0] fix_quo;
  logic [XLEN-1:0] fix_rem;
  logic [XLEN-1:0] fix_sel;
  logic [XLEN-1:0] fix_result;

  assign accept = req_valid && (state_q == IDLE);

  // Operand preparation: word narrowing, then sign/magnitude split for signed ops.
  always_comb begin
    op1_ext = operand1;
    op2_ext = operand2;
    if (div_op[2]) begin
      if (div_op[0]) begin
        op1_ext = {{HALF{1'b0}}, operand1[HALF-1:0]};
        op2_ext = {{HALF{1'b0}}, operand2[HALF-1:0]};
      end else begin
        op1_ext = {{HALF{operand1[HALF-1]}}, operand1[HALF-1:0]};
        op2_ext = {{HALF{operand2[HALF-1]}}, operand2[HALF-1:0]};
      end
    end
    op1_neg  = !div_op[0] && op1_ext[XLEN-1];
    op2_neg  = !div_op[0] && op2_ext[XLEN-1];
    op1_mag  = op1_neg ? (~op1_ext + 1'b1) : op1_ext;
    op2_mag  = op2_neg ? (~op2_ext + 1'b1) : op2_ext;
    op2_zero = (op2_ext == '0);
  end

`ifdef DIV_EARLY_OUT_EN
  // Word magnitudes fit in the low half, so parking them high saves 32 shifts.
  assign quo_init = div_op[2] ? {op1_mag[HALF-1:0], {HALF{1'b0}}} : op1_mag;
  assign last_cnt = word_q ? 7'(HALF - 1) : 7'(XLEN - 1);
`else
  assign quo_init = op1_mag;
  assign last_cnt = 7'(XLEN - 1);
`endif

  // One restoring step: 65-bit partial remainder since the shifted value can exceed 64 bits.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, dvsr_mag_q};
    rem_ge    = (rem_shift >= {1'b0, dvsr_mag_q});
    rem_nxt   = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  end

  always_comb begin
    fix_quo = quo_q;
    fix_rem = rem_q;
    if (dvsr_zero_q) begin
      fix_quo = '1;
      fix_rem = dvnd_prep_q;
    end else if (!unsigned_q) begin
      if (dvnd_neg_q ^ dvsr_neg_q) begin
        fix_quo = ~quo_q + 1'b1;
      end
      if (dvnd_neg_q) begin
        fix_rem = ~rem_q + 1'b1;
      end
    end
    fix_sel    = want_rem_q ? fix_rem : fix_quo;
    fix_result = word_q ? {{HALF{fix_sel[HALF-1]}}, fix_sel[HALF-1:0]} : fix_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
`ifdef DIV_EARLY_OUT_EN
          state_d = op2_zero ? FIXUP : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt_q == last_cnt) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_mag_q  <= '0;
      dvnd_prep_q <= '0;
      unsigned_q  <= 1'b0;
      want_rem_q  <= 1'b0;
      word_q      <= 1'b0;
      dvnd_neg_q  <= 1'b0;
      dvsr_neg_q  <= 1'b0;
      dvsr_zero_q <= 1'b0;
      resp_result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= quo_init;
            dvsr_mag_q  <= op2_mag;
            dvnd_prep_q <= op1_ext;
            unsigned_q  <= div_op[0];
            want_rem_q  <= div_op[1];
            word_q      <= div_op[2];
            dvnd_neg_q  <= op1_neg;
            dvsr_neg_q  <= op2_neg;
            dvsr_zero_q <= op2_zero;
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[XLEN-2:0], rem_ge};
          cnt_q <= (cnt_q == last_cnt) ? 7'd0 : cnt_q + 7'd1;
        end
        FIXUP: begin
          resp_result <= fix_result;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Randomized and directed checks of div_radix2 against a plain-arithmetic RV64M divide model.
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] operand1;
  logic [63:0] operand2;
  logic [2:0]  div_op;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_result;

  int n_chk  = 0;
  int n_pass = 0;
  int resp_cnt = 0;
  int resp_exp = 0;

  always #5 clk = ~clk;

  div_radix2 #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .operand1   (operand1),
    .operand2   (operand2),
    .div_op     (div_op),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_result(resp_result)
  );

  always @(posedge clk) if (resp_valid && !rst) resp_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_result(input logic [63:0] a_in, input logic [63:0] b_in,
                                             input logic [2:0] op);
    logic [63:0] a, b, q, r, res;
    logic signed [63:0] sa, sb;
    a = a_in;
    b = b_in;
    if (op[2]) begin
      a = op[0] ? {32'b0, a_in[31:0]} : {{32{a_in[31]}}, a_in[31:0]};
      b = op[0] ? {32'b0, b_in[31:0]} : {{32{b_in[31]}}, b_in[31:0]};
    end
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = '1;
      r = a;
    end else if (op[0]) begin
      q = a / b;
      r = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a;
      r = 64'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    res = op[1] ? r : q;
    if (op[2]) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  function automatic int ref_latency(input logic [63:0] b, input logic [2:0] op);
`ifdef DIV_EARLY_OUT_EN
    if ((op[2] ? b[31:0] == 32'd0 : b == 64'd0)) return 2;
    if (op[2]) return 34;
`endif
    return 66;
  endfunction

  // Called at the first negedge after the accept edge; k counts edges since accept.
  task automatic wait_resp(input string tag, input logic [63:0] exp_val, input int exp_lat);
    int k;
    k = 1;
    while (!resp_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_lat"}, 64'(k), 64'(exp_lat));
    check_eq({tag, "_res"}, resp_result, exp_val);
    resp_exp++;
    @(negedge clk);
    check_eq({tag, "_pulse"}, {63'b0, resp_valid}, 64'd0);
    check_eq({tag, "_hold"}, resp_result, exp_val);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_timeout", {63'b0, req_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] op);
    @(negedge clk);
    wait_ready();
    operand1  = a;
    operand2  = b;
    div_op    = op;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    operand1  = {$urandom, $urandom};
    operand2  = {$urandom, $urandom};
    div_op    = 3'($urandom);
    wait_resp(tag, ref_result(a, b, op), ref_latency(b, op));
  endtask

  typedef struct {
    string       tag;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
  } vec_t;

  vec_t dir[$];

  initial begin
    logic [63:0] a, b, a2, b2, res_a;
    logic [2:0]  op;
    int          low, pulses, lat_a, c0, sel;

    rst = 1'b1; req_valid = 1'b0;
    operand1 = '0; operand2 = '0; div_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {63'b0, req_ready}, 64'd1);
    check_eq("rst_valid", {63'b0, resp_valid}, 64'd0);
    check_eq("rst_result", resp_result, 64'd0);
    rst = 1'b0;

    dir.push_back('{"div_neg7_2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b000});
    dir.push_back('{"rem_neg7_2",  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'b010});
    dir.push_back('{"divu_by0",    64'd123, 64'd0, 3'b001});
    dir.push_back('{"remu_by0",    64'd123, 64'd0, 3'b011});
    dir.push_back('{"rem_neg5_0",  64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 3'b010});
    dir.push_back('{"div_ovf",     64'h8000_0000_0000_0000, '1, 3'b000});
    dir.push_back('{"rem_ovf",     64'h8000_0000_0000_0000, '1, 3'b010});
    dir.push_back('{"divw",        64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 3'b100});
    dir.push_back('{"divuw",       64'h0000_0000_FFFF_FFFF, 64'd2, 3'b101});
    dir.push_back('{"remw",        64'h0000_0000_FFFF_FFF9, 64'd2, 3'b110});
    dir.push_back('{"remuw_by0",   64'hDEAD_BEEF_8000_0005, 64'hFFFF_FFFF_0000_0000, 3'b111});
    dir.push_back('{"divu_big",    '1, 64'd3, 3'b001});
    foreach (dir[i]) run_op(dir[i].tag, dir[i].a, dir[i].b, dir[i].op);

    // Back-to-back requests with req_valid held high the whole time.
    a = 64'd1_000_000_007; b = 64'hFFFF_FFFF_FFFF_FFF0;
    a2 = 64'hFFFF_FFFF_FFFF_0000; b2 = 64'd77;
    @(negedge clk);
    wait_ready();
    operand1 = a; operand2 = b; div_op = 3'b000; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    operand1 = a2; operand2 = b2; div_op = 3'b011;
    low = 0; pulses = 0; lat_a = 0; res_a = '0;
    for (int k = 1; k <= 66; k++) begin
      if (!req_ready) low++;
      if (resp_valid) begin
        pulses++;
        lat_a = k;
        res_a = resp_result;
      end
      @(negedge clk);
    end
    check_eq("hs_ready_low", 64'(low), 64'd66);
    check_eq("hs_pulses", 64'(pulses), 64'd1);
    check_eq("hs_lat_a", 64'(lat_a), 64'd66);
    check_eq("hs_res_a", res_a, ref_result(a, b, 3'b000));
    check_eq("hs_ready_back", {63'b0, req_ready}, 64'd1);
    resp_exp++;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("hs_b", ref_result(a2, b2, 3'b011), 66);

    // Reset mid-operation abandons the request.
    @(negedge clk);
    wait_ready();
    operand1 = 64'd1000; operand2 = 64'd3; div_op = 3'b001; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_ready", {63'b0, req_ready}, 64'd1);
    check_eq("abort_valid", {63'b0, resp_valid}, 64'd0);
    check_eq("abort_result", resp_result, 64'd0);
    c0 = resp_cnt;
    repeat (80) @(negedge clk);
    check_eq("abort_no_resp", 64'(resp_cnt), 64'(c0));
    run_op("after_abort", 64'd100, 64'd7, 3'b001);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      op = 3'($urandom);
      case (sel)
        0: b = 64'(b[7:0]);
        1: b = op[2] ? {b[63:32], 32'd0} : 64'd0;
        2: begin a = op[2] ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        3: a = 64'(a[15:0]);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), a, b, op);
    end

    @(negedge clk);
    check_eq("resp_count", 64'(resp_cnt), 64'(resp_exp));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
